divider_replica_monitor: RTL and testbench
==========================================

# divider_replica_monitor

Runtime timing monitor for the divider critical path. Periodically launches a transition into the divider's inverter-chain delay replica and samples the replica output one clock later. A late arrival means the real divider path is also at risk. Consecutive failures switch the divider into a conservative two-cycle slow mode; consecutive passes with hysteresis switch it back. Sits beside the divider in the execute stage and drives the divider's slow-mode control.

## Interface
- PROBE_INTERVAL, 64: idle cycles between automatic probes; legal range 4..65535.
- FAIL_THRESH, 2: consecutive failed probes needed to enter slow mode; 1..15.
- PASS_THRESH, 16: consecutive passing probes needed to leave slow mode; 1..255.
- REPLICA_INVERTING, 0: 1 if the replica output is the inverse of its input.
- CNT_W, 16: width of the failure statistics counter.
- clk_i  in  1  single clock.
- rst_ni  in  1  asynchronous, active-low reset.
- enable_i  in  1  enables automatic and forced probing.
- force_probe_i  in  1  one-cycle request to probe immediately.
- div_busy_i  in  1  divider mid-operation; slow-mode changes are deferred while high.
- replica_out_i  in  1  output of the delay replica.
- replica_in_o  out  1  registered launch value driving the replica input.
- slow_mode_o  out  1  divider must use two-cycle evaluation.
- violation_o  out  1  one-cycle pulse on a failed probe.
- probe_done_o  out  1  one-cycle pulse when any probe completes.
- clr_count_i  in  1  clears fail_count_o (statistics build only).
- fail_count_o  out  CNT_W  saturating total of failed probes.

## Operation
- Probe FSM states:
  - IDLE: the interval counter increments while enable_i=1 and is held at 0 while enable_i=0. Go to LAUNCH when the counter reaches PROBE_INTERVAL-1, or when force_probe_i=1 and enable_i=1. The counter clears on that transition.
  - LAUNCH (1 cycle): always goes to EVAL.
  - EVAL (1 cycle): always goes to IDLE.
- On the IDLE->LAUNCH edge:
  - replica_in_o <= ~replica_in_o.
  - The expected value is registered as exp = ~replica_in_o ^ REPLICA_INVERTING.
- On the LAUNCH->EVAL edge, capture replica_out_i into cap. This is a full-cycle path through the replica by construction.
- In EVAL, pass = (cap == exp).
  - On the edge leaving EVAL: probe_done_o <= 1 and violation_o <= ~pass.
- Mode control runs in two modes, NORMAL and SLOW, with counters fail_run (4 bit) and pass_run (8 bit):
  - NORMAL: a fail increments fail_run; a pass clears it. When fail_run reaches FAIL_THRESH, request SLOW.
  - SLOW: a pass increments pass_run; a fail clears it. When pass_run reaches PASS_THRESH, request NORMAL.
  - On a mode change, clear both run counters.
- A requested mode change is held pending and applied to slow_mode_o on the first edge where div_busy_i=0. While pending, further probe results keep updating the run counters of the target mode.
- force_probe_i is ignored outside IDLE; it is not queued.
- Deasserting enable_i mid-probe does not abort the probe: it completes and results apply. slow_mode_o holds its value while disabled.

## Timing
- Reset values: state IDLE, interval counter 0, replica_in_o=0, slow_mode_o=1 (conservative), violation_o=0, probe_done_o=0, fail_count_o=0, run counters 0.
- Latency: force_probe_i high in cycle t (IDLE, enabled):
  - LAUNCH in t+1, EVAL in t+2.
  - probe_done_o and violation_o high in t+3 only.
  - Earliest slow_mode_o change is visible in t+3 if div_busy_i=0 in t+2.
- Automatic probes start every PROBE_INTERVAL+2 cycles.
- Interval counter wrap: it clears to 0 on every LAUNCH, so it never wraps.
- Asserting rst_ni mid-probe returns all state to the reset values asynchronously; there is no partial result.

## Configuration
- DIV_REPLICA_MON_STATS_EN defined:
  - fail_count_o increments on each failed probe and saturates at 2^CNT_W-1.
  - clr_count_i clears it; clear wins over a simultaneous increment.
- Not defined: fail_count_o is tied to 0, clr_count_i is ignored, and no counter flops are built.

## Test plan
- Reset release, replica_out_i tied to track replica_in_o, PROBE_INTERVAL=4 -> probe_done_o every 6 cycles; slow_mode_o falls after 16 passes (PASS_THRESH=16); violation_o stays 0.
- In NORMAL, replica_out_i stuck at its old value, 2 forced probes -> violation_o pulses at t+3 of each probe; slow_mode_o=1 after the second.
- Pass/fail alternation fail, pass, fail in NORMAL with FAIL_THRESH=2 -> fail_run resets; slow_mode_o stays 0.
- Mode change pending with div_busy_i=1 for 10 cycles -> slow_mode_o changes exactly one cycle after div_busy_i falls.
- force_probe_i during LAUNCH, and enable_i=0 during EVAL -> the force is ignored, the in-flight probe completes, and no further probes occur.
- STATS build, CNT_W=2, 5 failures, then clr_count_i coinciding with a failure -> fail_count_o saturates at 3, then reads 0.

Source files
------------

// File: rtl/divider_replica_monitor.sv
// Timing monitor for the divider critical path. It probes an inverter-chain replica
// and switches the divider into, and back out of, a two-cycle slow mode.
// Optional failure statistics counter: define DIV_REPLICA_MON_STATS_EN.
module divider_replica_monitor #(
  parameter int unsigned PROBE_INTERVAL    = 64,
  parameter int unsigned FAIL_THRESH       = 2,
  parameter int unsigned PASS_THRESH       = 16,
  parameter bit          REPLICA_INVERTING = 1'b0,
  parameter int unsigned CNT_W             = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             enable_i,
  input  logic             force_probe_i,
  input  logic             div_busy_i,
  input  logic             replica_out_i,
  output logic             replica_in_o,
  output logic             slow_mode_o,
  output logic             violation_o,
  output logic             probe_done_o,
  input  logic             clr_count_i,
  output logic [CNT_W-1:0] fail_count_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_EVAL   = 2'd2
  } state_t;

  localparam logic [15:0] IVL_LAST = 16'(PROBE_INTERVAL - 1);
  localparam logic [3:0]  FAIL_LIM = 4'(FAIL_THRESH);
  localparam logic [7:0]  PASS_LIM = 8'(PASS_THRESH);

  state_t      state_reg, state_next;
  logic [15:0] ivl_reg, ivl_next;
  logic        launch;
  logic        eval;
  logic        probe_pass;

  logic        replica_in_reg;
  logic        exp_reg;
  logic        cap_reg;
  logic        probe_done_reg;
  logic        violation_reg;

  // mode_slow_reg is the target mode; slow_mode_reg is what the divider sees.
  logic        mode_slow_reg, mode_slow_next;
  logic        slow_mode_reg, slow_mode_next;
  logic [3:0]  fail_run_reg, fail_run_next;
  logic [7:0]  pass_run_reg, pass_run_next;

  // Probe sequencer
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg <= ST_IDLE;
      ivl_reg   <= '0;
    end else begin
      state_reg <= state_next;
      ivl_reg   <= ivl_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    ivl_next   = ivl_reg;
    launch     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (!enable_i) begin
          ivl_next = '0;
        end else if (force_probe_i || (ivl_reg == IVL_LAST)) begin
          state_next = ST_LAUNCH;
          ivl_next   = '0;
          launch     = 1'b1;
        end else begin
          ivl_next = ivl_reg + 16'd1;
        end
      end
      ST_LAUNCH: state_next = ST_EVAL;
      ST_EVAL:   state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  assign eval       = (state_reg == ST_EVAL);
  assign probe_pass = (cap_reg == exp_reg);

  // Launch, capture and result pulses
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      replica_in_reg <= 1'b0;
      exp_reg        <= 1'b0;
      cap_reg        <= 1'b0;
      probe_done_reg <= 1'b0;
      violation_reg  <= 1'b0;
    end else begin
      if (launch) begin
        replica_in_reg <= ~replica_in_reg;
        exp_reg        <= ~replica_in_reg ^ REPLICA_INVERTING;
      end
      if (state_reg == ST_LAUNCH) begin
        cap_reg <= replica_out_i;
      end
      probe_done_reg <= eval;
      violation_reg  <= eval & ~probe_pass;
    end
  end

  // Run counters always follow the target mode, even while a change is pending.
  always_comb begin
    mode_slow_next = mode_slow_reg;
    fail_run_next  = fail_run_reg;
    pass_run_next  = pass_run_reg;
    if (eval) begin
      if (!mode_slow_reg) begin
        if (probe_pass) begin
          fail_run_next = '0;
        end else if ((fail_run_reg + 4'd1) == FAIL_LIM) begin
          mode_slow_next = 1'b1;
          fail_run_next  = '0;
          pass_run_next  = '0;
        end else begin
          fail_run_next = fail_run_reg + 4'd1;
        end
      end else begin
        if (!probe_pass) begin
          pass_run_next = '0;
        end else if ((pass_run_reg + 8'd1) == PASS_LIM) begin
          mode_slow_next = 1'b0;
          fail_run_next  = '0;
          pass_run_next  = '0;
        end else begin
          pass_run_next = pass_run_reg + 8'd1;
        end
      end
    end
    slow_mode_next = div_busy_i ? slow_mode_reg : mode_slow_next;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mode_slow_reg <= 1'b1;
      slow_mode_reg <= 1'b1;
      fail_run_reg  <= '0;
      pass_run_reg  <= '0;
    end else begin
      mode_slow_reg <= mode_slow_next;
      slow_mode_reg <= slow_mode_next;
      fail_run_reg  <= fail_run_next;
      pass_run_reg  <= pass_run_next;
    end
  end

`ifdef DIV_REPLICA_MON_STATS_EN
  logic [CNT_W-1:0] fail_count_reg;

  // Clear takes priority over a failure landing in the same cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fail_count_reg <= '0;
    end else if (clr_count_i) begin
      fail_count_reg <= '0;
    end else if (eval && !probe_pass && (fail_count_reg != {CNT_W{1'b1}})) begin
      fail_count_reg <= fail_count_reg + 1'b1;
    end
  end

  assign fail_count_o = fail_count_reg;
`else
  logic unused_clr_count;
  assign unused_clr_count = clr_count_i;
  assign fail_count_o     = '0;
`endif

  assign replica_in_o = replica_in_reg;
  assign slow_mode_o  = slow_mode_reg;
  assign violation_o  = violation_reg;
  assign probe_done_o = probe_done_reg;

endmodule

// File: tb/tb_divider_replica_monitor.sv
// Directed bench for divider_replica_monitor with a queue of expected probe results.
// Built with or without DIV_REPLICA_MON_STATS_EN; the counter model follows the macro.
module tb_divider_replica_monitor;

  localparam int CNT_W = 2;
`ifdef DIV_REPLICA_MON_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic enable;
  logic force_probe;
  logic div_busy;
  logic replica_out;
  logic replica_in;
  logic slow_mode;
  logic violation;
  logic probe_done;
  logic clr_count;
  logic [CNT_W-1:0] fail_count;

  logic track;
  logic stuck;

  int total = 0;
  int bad   = 0;
  bit exp_q[$];
  int exp_fc = 0;

  assign replica_out = track ? replica_in : stuck;

  always #5 clk = ~clk;

  divider_replica_monitor #(
    .PROBE_INTERVAL   (4),
    .FAIL_THRESH      (2),
    .PASS_THRESH      (16),
    .REPLICA_INVERTING(1'b0),
    .CNT_W            (CNT_W)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .enable_i     (enable),
    .force_probe_i(force_probe),
    .div_busy_i   (div_busy),
    .replica_out_i(replica_out),
    .replica_in_o (replica_in),
    .slow_mode_o  (slow_mode),
    .violation_o  (violation),
    .probe_done_o (probe_done),
    .clr_count_i  (clr_count),
    .fail_count_o (fail_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_result(input string tag);
    bit e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s: observed=probe expected=none_queued", tag);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_viol"}, 32'(violation), 32'(e));
    end
  endtask

  // Forced probe launched from IDLE in cycle t; result is due in t+3 only.
  task automatic probe(input bit want_fail, input bit clr_eval, input bit exp_slow, input string tag);
    if (want_fail) begin
      stuck = replica_in;
      track = 1'b0;
    end else begin
      track = 1'b1;
    end
    enable      = 1'b1;
    force_probe = 1'b1;
    exp_q.push_back(want_fail);
    if (STATS) begin
      if (clr_eval) exp_fc = 0;
      else if (want_fail && exp_fc < 3) exp_fc++;
    end
    tick();
    enable      = 1'b0;
    force_probe = 1'b0;
    chk({tag, "_done_t1"}, 32'(probe_done), 32'd0);
    tick();
    clr_count = clr_eval;
    chk({tag, "_done_t2"}, 32'(probe_done), 32'd0);
    chk({tag, "_viol_t2"}, 32'(violation), 32'd0);
    tick();
    clr_count = 1'b0;
    chk({tag, "_done_t3"}, 32'(probe_done), 32'd1);
    chk_result(tag);
    chk({tag, "_slow"}, 32'(slow_mode), 32'(exp_slow));
    chk({tag, "_fc"}, 32'(fail_count), 32'(exp_fc));
    $display("probe %s: fail=%0b viol=%0b slow=%0b fc=%0d", tag, want_fail, violation, slow_mode, fail_count);
    tick();
    chk({tag, "_done_t4"}, 32'(probe_done), 32'd0);
  endtask

  initial begin
    int n_done;
    int last;
    int extra;

    rst_n       = 1'b0;
    enable      = 1'b0;
    force_probe = 1'b0;
    div_busy    = 1'b0;
    clr_count   = 1'b0;
    track       = 1'b1;
    stuck       = 1'b0;
    repeat (3) tick();
    chk("rst_replica_in", 32'(replica_in), 32'd0);
    chk("rst_slow", 32'(slow_mode), 32'd1);
    chk("rst_viol", 32'(violation), 32'd0);
    chk("rst_done", 32'(probe_done), 32'd0);
    chk("rst_fc", 32'(fail_count), 32'd0);

    // Automatic probing with a tracking replica: 16 passes leave slow mode.
    enable = 1'b1;
    rst_n  = 1'b1;
    repeat (16) exp_q.push_back(1'b0);
    n_done = 0;
    last   = -1;
    for (int i = 0; i < 200 && n_done < 16; i++) begin
      tick();
      if (probe_done) begin
        n_done++;
        chk_result($sformatf("auto%0d", n_done));
        if (last >= 0) chk($sformatf("auto%0d_spacing", n_done), 32'(i - last), 32'd6);
        last = i;
        if (n_done == 15) chk("auto15_slow", 32'(slow_mode), 32'd1);
        if (n_done == 16) chk("auto16_slow", 32'(slow_mode), 32'd0);
        $display("auto probe %0d at cycle %0d: viol=%0b slow=%0b", n_done, i, violation, slow_mode);
      end
    end
    enable = 1'b0;
    chk("auto_count", 32'(n_done), 32'd16);
    tick();

    // Two stuck-replica failures re-enter slow mode.
    probe(1'b1, 1'b0, 1'b0, "stuck1");
    probe(1'b1, 1'b0, 1'b1, "stuck2");

    // Sixteen passes return to normal; fail/pass/fail must not re-enter slow.
    for (int i = 1; i <= 16; i++) probe(1'b0, 1'b0, (i != 16), $sformatf("recover%0d", i));
    probe(1'b1, 1'b0, 1'b0, "alt_fail1");
    probe(1'b0, 1'b0, 1'b0, "alt_pass");
    probe(1'b1, 1'b0, 1'b0, "alt_fail2");

    // Second consecutive fail requests slow mode while the divider is busy.
    div_busy = 1'b1;
    probe(1'b1, 1'b0, 1'b0, "busy_fail");
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("busy_hold%0d", i), 32'(slow_mode), 32'd0);
    end
    div_busy = 1'b0;
    chk("busy_fall_same", 32'(slow_mode), 32'd0);
    tick();
    chk("busy_fall_next", 32'(slow_mode), 32'd1);
    $display("deferred mode change: slow=%0b one cycle after busy fell", slow_mode);

    // Force during LAUNCH is dropped; enable low in EVAL still completes the probe.
    track       = 1'b1;
    enable      = 1'b1;
    force_probe = 1'b1;
    exp_q.push_back(1'b0);
    tick();
    chk("inflight_done_t1", 32'(probe_done), 32'd0);
    tick();
    enable      = 1'b0;
    force_probe = 1'b0;
    chk("inflight_done_t2", 32'(probe_done), 32'd0);
    tick();
    chk("inflight_done_t3", 32'(probe_done), 32'd1);
    chk_result("inflight");
    chk("inflight_slow", 32'(slow_mode), 32'd1);
    extra = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (probe_done) extra++;
    end
    chk("no_extra_probe", 32'(extra), 32'd0);
    $display("in-flight probe: extra probes after disable=%0d", extra);

    // Statistics: clear, saturate, then clear against a coincident failure.
    clr_count = 1'b1;
    tick();
    clr_count = 1'b0;
    exp_fc    = 0;
    chk("stats_clr", 32'(fail_count), 32'd0);
    for (int i = 1; i <= 5; i++) probe(1'b1, 1'b0, 1'b1, $sformatf("stats_fail%0d", i));
    probe(1'b1, 1'b1, 1'b1, "stats_clr_fail");

    // Reset asserted mid-probe drops the probe entirely.
    track       = 1'b1;
    enable      = 1'b1;
    force_probe = 1'b1;
    tick();
    enable      = 1'b0;
    force_probe = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_replica_in", 32'(replica_in), 32'd0);
    chk("async_slow", 32'(slow_mode), 32'd1);
    chk("async_done", 32'(probe_done), 32'd0);
    chk("async_fc", 32'(fail_count), 32'd0);
    tick();
    rst_n = 1'b1;
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (probe_done || violation) extra++;
    end
    chk("async_no_result", 32'(extra), 32'd0);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("async reset mid-probe: late results=%0d", extra);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
